wb_write_arbiter: RTL

- Writeback-side initiator for the register file write port; produces the reg_write / write_reg / write_data triple the register file consumes.
- Merges two result sources:
  - a single-cycle ALU path, which has priority;
  - a long-latency memory/multiply path, buffered in a small in-order FIFO.
- Drops writes to x0.
- Bounds starvation of the buffered path by back-pressuring the ALU path.

---
 rtl/wb_write_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges a single-cycle ALU result stream with a buffered
// long-latency memory/multiply stream onto the register file write port.
module wb_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_WIDTH-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          reg_write,
    output logic [ADDR_WIDTH-1:0]         write_reg,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          pending,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [SW-1:0]         starve_q, starve_d;

    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  alu_win;

    // Readies decode registered state only, so a same-cycle pop never frees a slot.
    assign fifo_empty = (count_q == '0);
    assign mem_ready  = (count_q < DEPTH_C);
    assign alu_ready  = (starve_q != LIMIT_C);

    // Writes to x0 are accepted but dropped; the ALU zero case still lets the FIFO pop.
    assign push    = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_win = alu_valid && alu_ready && (alu_rd != '0);
    assign pop     = !alu_win && !fifo_empty;

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = mem_rd;
            fifo_data_d[wr_ptr_q] = mem_data;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Once the counter reaches the limit alu_ready drops, forcing a pop that clears it.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (alu_win) begin
            reg_write_d  = 1'b1;
            write_reg_d  = alu_rd;
            write_data_d = alu_data;
        end else if (pop) begin
            reg_write_d  = 1'b1;
            write_reg_d  = fifo_rd_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            fifo_rd_q    <= fifo_rd_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign pending    = !fifo_empty;
    assign fifo_count = count_q;

endmodule
